// File: rtl/cpu_elastic_buffer.sv
// cpu_elastic_buffer: DEPTH-entry valid/ready elastic buffer with optional zero-latency bypass and synchronous flush
module cpu_elastic_buffer #(
    parameter int DW          = 32,
    parameter int DEPTH       = 2,
    parameter bit PASSTHROUGH = 1'b1
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_flush,
    input  logic                       i_valid,
    input  logic [DW-1:0]              i_data,
    output logic                       o_ready,
    output logic                       o_valid,
    output logic [DW-1:0]              o_data,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, full, bypass_sel, push, pop, wr, rd;

    // handshake outputs and transfer decisions; o_ready never looks at i_ready
    always_comb begin
        empty      = count_q == '0;
        full       = count_q == CW'(DEPTH);
        bypass_sel = PASSTHROUGH && empty;
        o_ready    = !full && !i_flush && !i_reset;
        o_valid    = bypass_sel ? (i_valid && !i_flush && !i_reset) : (!empty && !i_flush);
        o_data     = bypass_sel ? i_data : mem_q[rd_ptr_q];
        o_count    = count_q;
        push       = i_valid && o_ready;
        pop        = o_valid && i_ready;
        wr         = push && !(bypass_sel && pop);
        rd         = pop && !empty;
    end

    // next pointers and occupancy; a flush discards everything
    always_comb begin
        rd_ptr_d = i_flush ? '0 : rd_ptr_q + AW'(rd);
        wr_ptr_d = i_flush ? '0 : wr_ptr_q + AW'(wr);
        count_d  = i_flush ? '0 : count_q + CW'(wr) - CW'(rd);
    end

    // pointer and count registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage write; contents need no reset since count gates visibility
    always_ff @(posedge i_clock) begin
        if (wr) mem_q[wr_ptr_q] <= i_data;
    end
endmodule

// File: tb/tb_cpu_elastic_buffer.sv
// tb_cpu_elastic_buffer: scenario and randomized checks of three buffer configurations against a queue model
module tb_cpu_elastic_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    localparam int DEP [3] = '{2, 4, 4};
    localparam bit PTM [3] = '{1'b1, 1'b1, 1'b0};

    logic       vin [3], rin [3], fin [3], rdy [3], vld [3];
    logic [7:0] din [3], dout [3];
    logic [1:0] c0;
    logic [2:0] c1, c2;
    int         cnt [3];
    logic [7:0] mq [3][$];
    int         tests = 0, fails = 0;
    bit         e_rdy, e_vld, e_push;
    logic [7:0] e_dat;
    int         e_cnt;

    cpu_elastic_buffer #(.DW(8), .DEPTH(2), .PASSTHROUGH(1'b1)) u0 (
        .i_clock(clk), .i_reset(rst), .i_flush(fin[0]), .i_valid(vin[0]), .i_data(din[0]),
        .o_ready(rdy[0]), .o_valid(vld[0]), .o_data(dout[0]), .i_ready(rin[0]), .o_count(c0));
    cpu_elastic_buffer #(.DW(8), .DEPTH(4), .PASSTHROUGH(1'b1)) u1 (
        .i_clock(clk), .i_reset(rst), .i_flush(fin[1]), .i_valid(vin[1]), .i_data(din[1]),
        .o_ready(rdy[1]), .o_valid(vld[1]), .o_data(dout[1]), .i_ready(rin[1]), .o_count(c1));
    cpu_elastic_buffer #(.DW(8), .DEPTH(4), .PASSTHROUGH(1'b0)) u2 (
        .i_clock(clk), .i_reset(rst), .i_flush(fin[2]), .i_valid(vin[2]), .i_data(din[2]),
        .o_ready(rdy[2]), .o_valid(vld[2]), .o_data(dout[2]), .i_ready(rin[2]), .o_count(c2));

    always_comb begin
        cnt[0] = int'(c0);
        cnt[1] = int'(c1);
        cnt[2] = int'(c2);
    end

    // Drive one cycle of inputs just after the edge, derive expectations from the queue
    // model, advance the model to its post-edge contents, then wait to the falling edge.
    task automatic step(input int k, input bit v, input logic [7:0] d, input bit r, input bit f);
        int n;
        bit pop;
        @(posedge clk);
        #1;
        vin[k] = v; din[k] = d; rin[k] = r; fin[k] = f;
        n      = mq[k].size();
        e_cnt  = n;
        e_rdy  = !f && n < DEP[k];
        e_vld  = !f && (n > 0 || (PTM[k] && v));
        e_dat  = n > 0 ? mq[k][0] : d;
        e_push = v && e_rdy;
        pop    = e_vld && r;
        if (f) mq[k].delete();
        else begin
            if (pop && n > 0) void'(mq[k].pop_front());
            if (e_push && !(pop && n == 0)) mq[k].push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vin[k] = 1'b1; din[k] = 8'h5A; rin[k] = 1'b1; fin[k] = 1'b0;
        end
        #3;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (rdy[k] !== 1'b0 || vld[k] !== 1'b0 || cnt[k] != 0) begin
                fails++;
                $display("FAIL reset k=%0d got rdy=%b vld=%b cnt=%0d want 0 0 0", k, rdy[k], vld[k], cnt[k]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            vin[k] = 1'b0; rin[k] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        logic [7:0] w [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b1, w[i], 1'b1, 1'b0);
            tests++;
            if (vld[0] !== 1'b1 || dout[0] !== w[i] || cnt[0] != 0) begin
                fails++;
                $display("FAIL streaming i=%0d got vld=%b data=%0h cnt=%0d want 1 %0h 0", i, vld[0], dout[0], cnt[0], w[i]);
            end
        end
        step(0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_fill_drain();
        logic [7:0] w [3] = '{8'hA0, 8'hA1, 8'hA2};
        bit         vv [3] = '{1'b1, 1'b1, 1'b0};
        step(0, 1'b1, 8'hA0, 1'b0, 1'b0);
        step(0, 1'b1, 8'hA1, 1'b0, 1'b0);
        step(0, 1'b1, 8'hA2, 1'b0, 1'b0);
        tests++;
        if (rdy[0] !== 1'b0 || cnt[0] != 2 || vld[0] !== 1'b1 || dout[0] !== 8'hA0) begin
            fails++;
            $display("FAIL fill_full got rdy=%b cnt=%0d vld=%b data=%0h want 0 2 1 a0", rdy[0], cnt[0], vld[0], dout[0]);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, vv[i], 8'hA2, 1'b1, 1'b0);
            tests++;
            if (vld[0] !== 1'b1 || dout[0] !== w[i]) begin
                fails++;
                $display("FAIL drain i=%0d got vld=%b data=%0h want 1 %0h", i, vld[0], dout[0], w[i]);
            end
        end
        step(0, 1'b0, 8'h00, 1'b0, 1'b0);
        tests++;
        if (cnt[0] != 0 || rdy[0] !== 1'b1) begin
            fails++;
            $display("FAIL drain_empty got cnt=%0d rdy=%b want 0 1", cnt[0], rdy[0]);
        end
    endtask

    task automatic test_simultaneous();
        step(1, 1'b1, 8'hB0, 1'b0, 1'b0);
        step(1, 1'b1, 8'hB1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1, 1'b1, 8'hB2 + 8'(i), 1'b1, 1'b0);
            tests++;
            if (cnt[1] != 2 || dout[1] !== 8'hB0 + 8'(i) || rdy[1] !== 1'b1) begin
                fails++;
                $display("FAIL simul i=%0d got cnt=%0d data=%0h rdy=%b want 2 %0h 1", i, cnt[1], dout[1], rdy[1], 8'hB0 + 8'(i));
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1, 1'b0, 8'h00, 1'b1, 1'b0);
            tests++;
            if (cnt[1] != 2 - i || dout[1] !== 8'hB6 + 8'(i) || vld[1] !== 1'b1) begin
                fails++;
                $display("FAIL simul_drain i=%0d got cnt=%0d data=%0h want %0d %0h", i, cnt[1], dout[1], 2 - i, 8'hB6 + 8'(i));
            end
        end
        step(1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_registered();
        step(2, 1'b1, 8'h55, 1'b1, 1'b0);
        tests++;
        if (vld[2] !== 1'b0 || rdy[2] !== 1'b1) begin
            fails++;
            $display("FAIL reg_first got vld=%b rdy=%b want 0 1", vld[2], rdy[2]);
        end
        step(2, 1'b0, 8'h00, 1'b1, 1'b0);
        tests++;
        if (vld[2] !== 1'b1 || dout[2] !== 8'h55 || cnt[2] != 1) begin
            fails++;
            $display("FAIL reg_out got vld=%b data=%0h cnt=%0d want 1 55 1", vld[2], dout[2], cnt[2]);
        end
        step(2, 1'b0, 8'h00, 1'b0, 1'b0);
        tests++;
        if (vld[2] !== 1'b0 || cnt[2] != 0) begin
            fails++;
            $display("FAIL reg_empty got vld=%b cnt=%0d want 0 0", vld[2], cnt[2]);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) step(1, 1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
        step(1, 1'b1, 8'hEE, 1'b0, 1'b1);
        tests++;
        if (vld[1] !== 1'b0 || rdy[1] !== 1'b0 || cnt[1] != 3) begin
            fails++;
            $display("FAIL flush_cycle got vld=%b rdy=%b cnt=%0d want 0 0 3", vld[1], rdy[1], cnt[1]);
        end
        step(1, 1'b0, 8'h00, 1'b0, 1'b0);
        tests++;
        if (vld[1] !== 1'b0 || rdy[1] !== 1'b1 || cnt[1] != 0) begin
            fails++;
            $display("FAIL flush_after got vld=%b rdy=%b cnt=%0d want 0 1 0", vld[1], rdy[1], cnt[1]);
        end
        step(1, 1'b1, 8'h42, 1'b0, 1'b0);
        step(1, 1'b0, 8'h00, 1'b1, 1'b0);
        tests++;
        if (vld[1] !== 1'b1 || dout[1] !== 8'h42 || cnt[1] != 1) begin
            fails++;
            $display("FAIL flush_next got vld=%b data=%0h cnt=%0d want 1 42 1", vld[1], dout[1], cnt[1]);
        end
        step(1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        step(1, 1'b1, 8'hC0, 1'b0, 1'b0);
        step(1, 1'b1, 8'hC1, 1'b0, 1'b0);
        step(1, 1'b0, 8'h00, 1'b0, 1'b0);
        tests++;
        if (cnt[1] != 2) begin
            fails++;
            $display("FAIL rstmid_pre got cnt=%0d want 2", cnt[1]);
        end
        vin[1] = 1'b1; din[1] = 8'h99;
        #2 rst = 1'b1;
        #1;
        tests++;
        if (vld[1] !== 1'b0 || rdy[1] !== 1'b0 || cnt[1] != 0) begin
            fails++;
            $display("FAIL rstmid got vld=%b rdy=%b cnt=%0d want 0 0 0", vld[1], rdy[1], cnt[1]);
        end
        for (int k = 0; k < 3; k++) mq[k].delete();
        vin[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1, 1'b1, 8'h07, 1'b0, 1'b0);
        step(1, 1'b0, 8'h00, 1'b1, 1'b0);
        tests++;
        if (vld[1] !== 1'b1 || dout[1] !== 8'h07 || cnt[1] != 1) begin
            fails++;
            $display("FAIL rstmid_after got vld=%b data=%0h cnt=%0d want 1 07 1", vld[1], dout[1], cnt[1]);
        end
        step(1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random(input int k);
        bit         hv = 1'b0, r, f;
        logic [7:0] hd = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if (!hv) begin
                hv = $urandom_range(0, 3) != 0;
                hd = 8'($urandom);
            end
            r = $urandom_range(0, 2) != 0;
            f = $urandom_range(0, 15) == 0;
            step(k, hv, hd, r, f);
            tests++;
            if (rdy[k] !== e_rdy || vld[k] !== e_vld || cnt[k] != e_cnt || cnt[k] > DEP[k] || (e_vld && dout[k] !== e_dat)) begin
                fails++;
                $display("FAIL random k=%0d cyc=%0d got rdy=%b vld=%b cnt=%0d data=%0h want rdy=%b vld=%b cnt=%0d data=%0h",
                         k, i, rdy[k], vld[k], cnt[k], dout[k], e_rdy, e_vld, e_cnt, e_dat);
            end
            if (e_push || f) hv = 1'b0;
        end
        step(k, 1'b0, 8'h00, 1'b0, 1'b1);
        step(k, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill_drain();
        test_simultaneous();
        test_registered();
        test_flush();
        test_reset_mid();
        for (int k = 0; k < 3; k++) test_random(k);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
